// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet transmit framer:
//   - tx_state_e     : framer state encoding
//   - PREAMBLE_BYTE  : 0x55 preamble octet
//   - SFD_BYTE       : 0xD5 start-of-frame delimiter
//   - CRC_POLY       : reflected CRC-32 polynomial
//   - CRC_INIT       : CRC-32 preset value
//   - crc32_bit()    : single-bit step of the reflected CRC-32 LFSR
// ---------------------------------------------------------------------------
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_PAD      = 3'd4,
    ST_FCS      = 3'd5,
    ST_IFG      = 3'd6,
    ST_DISCARD  = 3'd7
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  // Number of 0x55 octets preceding the SFD.
  localparam int          PREAMBLE_LEN  = 7;
  // Saturation value of the 11-bit payload counter.
  localparam logic [10:0] PAYLOAD_MAX   = 11'd2047;

  // One LSB-first step of the reflected CRC-32 shift register.
  function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic din);
    logic fb;
    fb = crc[0] ^ din;
    crc32_bit = fb ? ((crc >> 1) ^ CRC_POLY) : (crc >> 1);
  endfunction

endpackage : eth_pkg

// File: rtl/eth_crc32_byte.sv
// ---------------------------------------------------------------------------
// eth_crc32_byte
// Purely combinational CRC-32 update for one octet, bits consumed LSB first
// (the order they go on the wire). The running CRC register lives in the
// caller; this block only computes the next value.
//
// Ports:
//   crc_in   in  32  current (uncomplemented) CRC value
//   data_in  in   8  octet to fold into the CRC
//   crc_out  out 32  CRC value after data_in
// ---------------------------------------------------------------------------
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] crc_work;

  always_comb begin
    crc_work = crc_in;
    for (int i = 0; i < 8; i++) begin
      crc_work = crc32_bit(crc_work, data_in[i]);
    end
    crc_out = crc_work;
  end

endmodule : eth_crc32_byte

// File: rtl/eth_tx_framer.sv
// ---------------------------------------------------------------------------
// eth_tx_framer
// Wraps a streamed payload (destination MAC onward) into an Ethernet frame:
// 7 x 0x55 preamble, 0xD5 SFD, payload, zero pad up to MIN_FRAME octets,
// 4-octet FCS (LSB first), followed by IFG_BYTES idle cycles. A payload
// stream that stalls mid-frame aborts the frame: the output is cut, the rest
// of the input frame is swallowed through s_last and the gap is still
// enforced.
//
// Parameters:
//   MIN_FRAME  minimum payload+pad octets before the FCS (0..64)
//   IFG_BYTES  idle cycles after each frame or abort (1..31)
//
// Ports:
//   clk         in   1  transmit clock
//   rst_n       in   1  asynchronous active-low reset
//   s_data      in   8  payload octet
//   s_valid     in   1  s_data valid
//   s_last      in   1  final payload octet (qualified by s_valid)
//   s_ready     out  1  octet accepted when s_valid && s_ready
//   tx_data     out  8  registered octet to the transmitter
//   tx_valid    out  1  registered, high from first preamble to last FCS octet
//   busy        out  1  high whenever the framer is not idle
//   frame_done  out  1  pulse on the first cycle after the last FCS octet
//   underrun    out  1  pulse on the cycle the aborted output is cut
// ---------------------------------------------------------------------------
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
  localparam logic [4:0]  IFG_LAST = 5'(IFG_BYTES - 1);
  localparam logic [4:0]  PRE_LAST = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0]  FCS_LAST = 5'd3;

  // State is "what is loaded into tx_data at the next edge". Hence the
  // cycle in which tx_data holds the SFD is the first DATA cycle, which is
  // exactly when payload must start being accepted.
  tx_state_e   state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        underrun_q, underrun_d;
  // Shared small counter: preamble octets, FCS octet index, IFG cycles.
  logic [4:0]  cnt_q, cnt_d;
  logic [10:0] payload_cnt_q, payload_cnt_d;
  logic [31:0] crc_q, crc_d;

  logic [7:0]  crc_data;
  logic [31:0] crc_next;
  logic [31:0] crc_fcs;
  logic [7:0]  fcs_byte;
  logic [10:0] payload_inc;

  // Pad octets are zero; everything else folded into the CRC is payload.
  assign crc_data = (state_q == ST_PAD) ? 8'h00 : s_data;

  eth_crc32_byte u_crc (
    .crc_in  (crc_q),
    .data_in (crc_data),
    .crc_out (crc_next)
  );

  assign payload_inc = (payload_cnt_q == PAYLOAD_MAX) ? payload_cnt_q
                                                      : payload_cnt_q + 11'd1;

  // The register keeps the raw CRC; the FCS on the wire is its complement.
  assign crc_fcs = ~crc_q;

  always_comb begin
    fcs_byte = crc_fcs[7:0];
    case (cnt_q[1:0])
      2'd0:    fcs_byte = crc_fcs[7:0];
      2'd1:    fcs_byte = crc_fcs[15:8];
      2'd2:    fcs_byte = crc_fcs[23:16];
      default: fcs_byte = crc_fcs[31:24];
    endcase
  end

  assign s_ready    = (state_q == ST_DATA) || (state_q == ST_DISCARD);
  assign busy       = (state_q != ST_IDLE);
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

  always_comb begin
    state_d       = state_q;
    tx_data_d     = 8'h00;
    tx_valid_d    = 1'b0;
    frame_done_d  = 1'b0;
    underrun_d    = 1'b0;
    cnt_d         = cnt_q;
    payload_cnt_d = payload_cnt_q;
    crc_d         = crc_q;

    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          tx_data_d     = PREAMBLE_BYTE;
          tx_valid_d    = 1'b1;
          cnt_d         = 5'd1;
          payload_cnt_d = 11'd0;
          crc_d         = CRC_INIT;
          state_d       = ST_PREAMBLE;
        end
      end

      ST_PREAMBLE: begin
        tx_data_d  = PREAMBLE_BYTE;
        tx_valid_d = 1'b1;
        cnt_d      = cnt_q + 5'd1;
        if (cnt_q == PRE_LAST) begin
          state_d = ST_SFD;
        end
      end

      ST_SFD: begin
        tx_data_d  = SFD_BYTE;
        tx_valid_d = 1'b1;
        state_d    = ST_DATA;
      end

      ST_DATA: begin
        if (s_valid) begin
          tx_data_d     = s_data;
          tx_valid_d    = 1'b1;
          crc_d         = crc_next;
          payload_cnt_d = payload_inc;
          if (s_last) begin
            cnt_d   = 5'd0;
            state_d = (payload_inc < MIN_LEN) ? ST_PAD : ST_FCS;
          end
        end else begin
          // Stream starved while we owe the wire a byte: cut the frame.
          underrun_d = 1'b1;
          state_d    = ST_DISCARD;
        end
      end

      ST_PAD: begin
        tx_data_d     = 8'h00;
        tx_valid_d    = 1'b1;
        crc_d         = crc_next;
        payload_cnt_d = payload_inc;
        if (payload_inc >= MIN_LEN) begin
          cnt_d   = 5'd0;
          state_d = ST_FCS;
        end
      end

      ST_FCS: begin
        tx_data_d  = fcs_byte;
        tx_valid_d = 1'b1;
        cnt_d      = cnt_q + 5'd1;
        if (cnt_q == FCS_LAST) begin
          cnt_d   = 5'd0;
          state_d = ST_IFG;
        end
      end

      ST_IFG: begin
        // tx_valid_q is still high only on the first gap cycle after a
        // completed frame (an aborted frame reaches here with it low).
        frame_done_d = tx_valid_q;
        cnt_d        = cnt_q + 5'd1;
        if (cnt_q == IFG_LAST) begin
          cnt_d   = 5'd0;
          state_d = ST_IDLE;
        end
      end

      ST_DISCARD: begin
        if (s_valid && s_last) begin
          cnt_d   = 5'd0;
          state_d = ST_IFG;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      underrun_q    <= 1'b0;
      cnt_q         <= 5'd0;
      payload_cnt_q <= 11'd0;
      crc_q         <= CRC_INIT;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      frame_done_q  <= frame_done_d;
      underrun_q    <= underrun_d;
      cnt_q         <= cnt_d;
      payload_cnt_q <= payload_cnt_d;
      crc_q         <= crc_d;
    end
  end

endmodule : eth_tx_framer

// File: tb/tb_eth_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_framer
// Scoreboard bench for eth_tx_framer. Two instances share the clock/reset:
// dut_a with MIN_FRAME=0 (check-value frame) and dut_b with defaults. The
// stimulus pushes expected tx octets, run lengths and gap lengths into
// queues; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eth_tx_framer;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       sel;

  logic       a_s_ready, a_tx_valid, a_busy, a_frame_done, a_underrun;
  logic [7:0] a_tx_data;
  logic       b_s_ready, b_tx_valid, b_busy, b_frame_done, b_underrun;
  logic [7:0] b_tx_data;
  logic       a_s_valid, b_s_valid;

  logic       m_s_ready, m_tx_valid, m_busy, m_frame_done, m_underrun;
  logic [7:0] m_tx_data;

  always #4 clk = ~clk;

  assign a_s_valid    = s_valid & ~sel;
  assign b_s_valid    = s_valid & sel;
  assign m_s_ready    = sel ? b_s_ready    : a_s_ready;
  assign m_tx_valid   = sel ? b_tx_valid   : a_tx_valid;
  assign m_tx_data    = sel ? b_tx_data    : a_tx_data;
  assign m_busy       = sel ? b_busy       : a_busy;
  assign m_frame_done = sel ? b_frame_done : a_frame_done;
  assign m_underrun   = sel ? b_underrun   : a_underrun;

  eth_tx_framer #(.MIN_FRAME(0), .IFG_BYTES(12)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(a_s_valid),
    .s_last(s_last), .s_ready(a_s_ready), .tx_data(a_tx_data),
    .tx_valid(a_tx_valid), .busy(a_busy), .frame_done(a_frame_done),
    .underrun(a_underrun)
  );

  eth_tx_framer dut_b (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(b_s_valid),
    .s_last(s_last), .s_ready(b_s_ready), .tx_data(b_tx_data),
    .tx_valid(b_tx_valid), .busy(b_busy), .frame_done(b_frame_done),
    .underrun(b_underrun)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  logic [7:0] exp_byte_q[$];
  int   exp_run_q[$];
  int   exp_gap_q[$];
  int   fd_count = 0;
  int   ur_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference CRC-32 (reflected, init all ones, complemented result).
  function automatic logic [31:0] crc_model(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[k]) begin
      c = c ^ {24'h0, b[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Push preamble, SFD, payload, pad and FCS for a complete frame.
  task automatic push_frame(input bq_t pl, input int minf);
    bq_t body;
    logic [31:0] fcs;
    body = pl;
    while (body.size() < minf) body.push_back(8'h00);
    fcs = crc_model(body);
    for (int k = 0; k < 7; k++) exp_byte_q.push_back(8'h55);
    exp_byte_q.push_back(8'hD5);
    foreach (body[k]) exp_byte_q.push_back(body[k]);
    for (int k = 0; k < 4; k++) exp_byte_q.push_back(fcs[8*k +: 8]);
  endtask

  // Monitor: compares every presented tx octet, run lengths, gap lengths
  // and the position of frame_done / underrun pulses.
  initial begin
    logic prev_valid;
    int   run_len;
    int   idle_run;
    prev_valid = 1'b0;
    run_len    = 0;
    idle_run   = 0;
    forever begin
      @(negedge clk);
      if (m_tx_valid) begin
        if (!prev_valid) begin
          if (exp_gap_q.size() > 0) chk("ifg_gap", idle_run, exp_gap_q.pop_front());
          run_len = 0;
        end
        run_len++;
        if (exp_byte_q.size() == 0) begin
          n_checks++;
          $display("FAIL tx_extra_byte: got 0x%0h, expected no octet", m_tx_data);
        end else begin
          chk("tx_data", m_tx_data, exp_byte_q.pop_front());
        end
      end else begin
        if (prev_valid && exp_run_q.size() > 0) chk("run_len", run_len, exp_run_q.pop_front());
        idle_run = prev_valid ? 1 : idle_run + 1;
      end
      if (m_frame_done) begin
        fd_count++;
        chk("frame_done_pos", {prev_valid, m_tx_valid}, 2'b10);
      end
      if (m_underrun) begin
        ur_count++;
        chk("underrun_pos", {prev_valid, m_tx_valid}, 2'b10);
      end
      prev_valid = m_tx_valid;
    end
  end

  // Drive a payload; optionally stall at drop_at or reset at rst_at
  // accepted octets. Returns after s_last is accepted (or after reset).
  task automatic send_frame(input bq_t pl, input bit hold, input int drop_at, input int rst_at);
    int i;
    int guard;
    bit acc;
    bit dropped;
    i = 0; guard = 0; dropped = 0;
    s_valid = 1'b1;
    s_data  = pl[0];
    s_last  = (pl.size() == 1);
    while (i < pl.size()) begin
      if (i == drop_at && !dropped) begin
        dropped = 1;
        s_valid = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b1;
      end
      @(negedge clk);
      acc = s_valid && m_s_ready;
      @(posedge clk); #1;
      guard++;
      if (guard > 400) begin
        chk("send_timeout", i, pl.size());
        break;
      end
      if (acc) begin
        i++;
        if (i < pl.size()) begin
          s_data = pl[i];
          s_last = (i == pl.size() - 1);
        end
        if (i == rst_at) begin
          #1 rst_n = 1'b0;
          #1;
          chk("rst_tx_valid",   m_tx_valid,   0);
          chk("rst_tx_data",    m_tx_data,    0);
          chk("rst_busy",       m_busy,       0);
          chk("rst_s_ready",    m_s_ready,    0);
          chk("rst_frame_done", m_frame_done, 0);
          chk("rst_underrun",   m_underrun,   0);
          exp_byte_q.delete();
          s_valid = 1'b0;
          s_last  = 1'b0;
          return;
        end
      end
    end
    s_last = 1'b0;
    if (!hold) s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_byte_q.size() == 0 && !m_busy) break;
    end
    if (k >= 300) chk("drain_timeout", exp_byte_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    bq_t pl;
    bq_t pl2;
    int  fd0;
    int  ur0;
    int  nb;

    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; sel = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_valid",   m_tx_valid,   0);
    chk("reset_tx_data",    m_tx_data,    0);
    chk("reset_busy",       m_busy,       0);
    chk("reset_s_ready",    m_s_ready,    0);
    chk("reset_frame_done", m_frame_done, 0);
    chk("reset_underrun",   m_underrun,   0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_s_ready", m_s_ready, 0);

    // Check-value frame on MIN_FRAME=0 instance: FCS of "123456789".
    sel = 1'b0;
    pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int k = 0; k < 7; k++) exp_byte_q.push_back(8'h55);
    exp_byte_q.push_back(8'hD5);
    foreach (pl[k]) exp_byte_q.push_back(pl[k]);
    exp_byte_q.push_back(8'h26); exp_byte_q.push_back(8'h39);
    exp_byte_q.push_back(8'hF4); exp_byte_q.push_back(8'hCB);
    exp_run_q.push_back(21);
    fd0 = fd_count;
    send_frame(pl, 1'b0, -1, -1);
    wait_drain();
    chk("t1_frame_done", fd_count - fd0, 1);
    $display("frame check_value: 9 payload octets, %0d/%0d so far", n_pass, n_checks);

    // 14-octet payload, padded to 60.
    sel = 1'b1;
    pl.delete();
    for (int k = 0; k < 14; k++) pl.push_back(8'(k * 7 + 3));
    push_frame(pl, 60);
    exp_run_q.push_back(72);
    fd0 = fd_count;
    send_frame(pl, 1'b0, -1, -1);
    wait_drain();
    chk("t2_frame_done", fd_count - fd0, 1);
    $display("frame pad: 14 payload octets, %0d/%0d so far", n_pass, n_checks);

    // 64-octet payload, no pad.
    pl.delete();
    for (int k = 0; k < 64; k++) pl.push_back(8'(255 - k));
    push_frame(pl, 60);
    exp_run_q.push_back(76);
    fd0 = fd_count;
    send_frame(pl, 1'b0, -1, -1);
    wait_drain();
    chk("t3_frame_done", fd_count - fd0, 1);
    $display("frame nopad: 64 payload octets, %0d/%0d so far", n_pass, n_checks);

    // Back-to-back with s_valid held high: gap must be exactly 12.
    pl.delete();
    for (int k = 0; k < 20; k++) pl.push_back(8'(k + 8'h40));
    pl2.delete();
    for (int k = 0; k < 61; k++) pl2.push_back(8'(k * 3));
    push_frame(pl, 60);
    exp_run_q.push_back(72);
    fd0 = fd_count;
    send_frame(pl, 1'b1, -1, -1);
    exp_gap_q.push_back(12);
    push_frame(pl2, 60);
    exp_run_q.push_back(73);
    send_frame(pl2, 1'b0, -1, -1);
    wait_drain();
    chk("t4_frame_done", fd_count - fd0, 2);
    chk("t4_gap_consumed", exp_gap_q.size(), 0);
    $display("frames back_to_back: 20+61 payload octets, %0d/%0d so far", n_pass, n_checks);

    // Stall at payload octet 20: output cut, rest discarded, 12-cycle gap.
    pl.delete();
    for (int k = 0; k < 40; k++) pl.push_back(8'(k + 8'h80));
    for (int k = 0; k < 7; k++) exp_byte_q.push_back(8'h55);
    exp_byte_q.push_back(8'hD5);
    for (int k = 0; k < 20; k++) exp_byte_q.push_back(pl[k]);
    exp_run_q.push_back(28);
    fd0 = fd_count;
    ur0 = ur_count;
    send_frame(pl, 1'b0, 20, -1);
    nb = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_busy) nb++;
      else break;
    end
    chk("t5_ifg_busy_cycles", nb, 12);
    wait_drain();
    chk("t5_underrun", ur_count - ur0, 1);
    chk("t5_no_frame_done", fd_count - fd0, 0);
    $display("frame abort: stall at octet 20, %0d/%0d so far", n_pass, n_checks);

    // Reset at payload octet 10, then a clean frame.
    pl.delete();
    for (int k = 0; k < 30; k++) pl.push_back(8'(k + 8'h10));
    push_frame(pl, 60);
    fd0 = fd_count;
    ur0 = ur_count;
    send_frame(pl, 1'b0, -1, 10);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_no_frame_done", fd_count - fd0, 0);
    chk("t6_no_underrun", ur_count - ur0, 0);
    pl.delete();
    for (int k = 0; k < 5; k++) pl.push_back(8'(k + 8'hA0));
    push_frame(pl, 60);
    exp_run_q.push_back(72);
    fd0 = fd_count;
    send_frame(pl, 1'b0, -1, -1);
    wait_drain();
    chk("t6_frame_done", fd_count - fd0, 1);
    chk("final_byte_queue", exp_byte_q.size(), 0);
    chk("final_run_queue", exp_run_q.size(), 0);
    $display("frame after_reset: 5 payload octets, %0d/%0d so far", n_pass, n_checks);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_eth_tx_framer

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter MIN_FRAME, default 60, SHALL set the minimum payload+pad byte count before FCS; legal range 0..64.
REQ-003 Parameter IFG_BYTES, default 12, SHALL set the idle cycles enforced after each frame or abort; legal range 1..31.
REQ-004 clk  in  1  125 MHz transmit clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 s_data  in  8  payload byte (destination MAC onward, no preamble, no FCS).
REQ-007 s_valid  in  1  s_data valid.
REQ-008 s_last  in  1  marks final payload byte; qualified by s_valid.
REQ-009 s_ready  out  1  byte accepted when s_valid && s_ready.
REQ-010 tx_data  out  8  registered byte to the RGMII transmitter.
REQ-011 tx_valid  out  1  registered; high for every byte from first preamble byte through last FCS byte, contiguous.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 frame_done  out  1  one-cycle pulse on the cycle after the last FCS byte leaves tx_data.
REQ-014 underrun  out  1  one-cycle pulse when a frame is aborted.

Function
REQ-015 States SHALL be IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG, DISCARD.
REQ-016 IDLE with s_valid high SHALL load 0x55 onto tx_data, tx_valid=1 at the next edge (latency 1 cycle); s_ready=0 in IDLE.
REQ-017 PREAMBLE SHALL present 7 bytes 0x55, then SFD SHALL present one byte 0xD5.
REQ-018 s_ready SHALL be high in the cycle tx_data holds 0xD5 and in every DATA cycle until the s_last byte is accepted; an accepted byte appears on tx_data at the next edge.
REQ-019 In DATA, s_valid low while s_ready high SHALL abort: tx_valid=0 next edge, underrun pulses, state goes DISCARD.
REQ-020 DISCARD SHALL hold s_ready=1 and drop input until s_last accepted, then enter IFG; no frame_done.
REQ-021 An 11-bit payload counter SHALL count accepted bytes, saturating at 2047.
REQ-022 After s_last, if count < MIN_FRAME, PAD SHALL emit 0x00 until payload+pad equals MIN_FRAME; count >= MIN_FRAME skips PAD.
REQ-023 CRC-32 SHALL be reflected polynomial 0xEDB88320, init 0xFFFFFFFF, over payload and pad only, result complemented.
REQ-024 FCS SHALL emit 4 bytes, least-significant byte first, immediately after the last payload/pad byte.
REQ-025 IFG SHALL hold tx_valid=0 and s_ready=0 for exactly IFG_BYTES cycles, then return to IDLE; s_valid during IFG waits.
REQ-026 A new frame SHALL start on the first IDLE cycle with s_valid high; back-to-back frames separated by exactly IFG_BYTES idle cycles.
REQ-027 Simultaneous s_last and abort cannot occur; s_last with s_valid high always completes normally.

Reset
REQ-028 On rst_n low: state=IDLE, tx_data=0x00, tx_valid=0, s_ready=0, busy=0, frame_done=0, underrun=0, counters=0, CRC=0xFFFFFFFF.
REQ-029 Reset asserted mid-frame SHALL truncate output immediately; no FCS, no frame_done, no underrun.

Structure
REQ-030 Shared package eth_pkg SHALL hold state enumeration, PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC_POLY, CRC_INIT.
REQ-031 One sub-module eth_crc32_byte SHALL compute the per-byte combinational CRC update; state and registers stay in eth_tx_framer.

Verification
REQ-032 MIN_FRAME=0, payload "123456789" -> tx sees 7x 0x55, 0xD5, 9 payload bytes, FCS 0x26 0x39 0xF4 0xCB, frame_done once.
REQ-033 Default params, 14-byte payload -> 46 bytes 0x00 pad, total tx_valid run 8+60+4=72 cycles, FCS matches software CRC-32.
REQ-034 64-byte payload -> no pad, tx_valid run 76 cycles.
REQ-035 Two frames with s_valid held high -> exactly 12 idle cycles between last FCS byte and next 0x55.
REQ-036 s_valid dropped at payload byte 20 -> underrun pulse, tx_valid low next edge, rest discarded through s_last, 12 idle cycles, no frame_done.
REQ-037 rst_n low at payload byte 10 -> all outputs at reset values asynchronously; next frame after release correct.
